// File: rtl/cronometro_pkg.sv
// Shared types and defaults for the stopwatch control front end.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE     = 20;
  localparam int DEFAULT_CLEAR_CYCLES = 2;

  // States in which the downstream counter keeps running
  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button conditioning: 2-flop synchroniser, debounce counter and a one-cycle
// press pulse on each rising edge of the debounced level.
module debouncer #(
  parameter int DEBOUNCE = 20
) (
  input  logic NEclk,
  input  logic Nreset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the NEclk domain
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Flip the level only after DEBOUNCE consecutive differing samples
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered rise detector; releases produce nothing
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      level_p2 <= 1'b0;
      press    <= 1'b0;
    end else begin
      level_p2 <= level;
      press    <= level & ~level_p2;
    end
  end

endmodule

// File: rtl/control_cronometro.sv
// Stopwatch control: conditions the start/stop and lap/reset buttons and runs
// the IDLE/RUN/PAUSE/LAP machine that drives the counter enable, the timed
// counter clear and the display lap-hold flag.
module control_cronometro
  import cronometro_pkg::*;
#(
  parameter int DEBOUNCE     = DEFAULT_DEBOUNCE,
  parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
  input  logic       NEclk,
  input  logic       Nreset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       Enable,
  output logic       Nclear,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int CLR_W = (CLEAR_CYCLES > 0) ? $clog2(CLEAR_CYCLES + 1) : 1;

  logic             ss_level;
  logic             ss_press;
  logic             lr_level;
  logic             lr_press;
  logic             ss_evt;
  logic             lr_evt;
  logic             load_clr;
  logic [CLR_W-1:0] clr_cnt;
  state_t           state_q;
  state_t           nxt;

  debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_ss (
    .NEclk  (NEclk),
    .Nreset (Nreset),
    .raw    (btn_start_stop),
    .level  (ss_level),
    .press  (ss_press)
  );

  debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_lr (
    .NEclk  (NEclk),
    .Nreset (Nreset),
    .raw    (btn_lap_reset),
    .level  (lr_level),
    .press  (lr_press)
  );

  // Press events are only honoured while the button is still held and no clear is in progress
  assign ss_evt = ss_press & ss_level & Nclear;
  assign lr_evt = lr_press & lr_level & Nclear;

  // Next-state decode; start/stop wins over lap/reset on a tie
  always_comb begin
    nxt      = state_q;
    load_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_evt) nxt = RUN;
      end
      RUN: begin
        if (ss_evt)      nxt = PAUSE;
        else if (lr_evt) nxt = LAP;
      end
      LAP: begin
        if (ss_evt)      nxt = PAUSE;
        else if (lr_evt) nxt = RUN;
      end
      PAUSE: begin
        if (ss_evt) begin
          nxt = RUN;
        end else if (lr_evt) begin
          nxt      = IDLE;
          load_clr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they move together
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state_q  <= IDLE;
      Enable   <= 1'b0;
      lap_hold <= 1'b0;
    end else begin
      state_q  <= nxt;
      Enable   <= is_counting(nxt);
      lap_hold <= (nxt == LAP);
    end
  end

  // Clear timer: Nclear stays low while the counter is non-zero
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      clr_cnt <= CLR_W'(CLEAR_CYCLES);
      Nclear  <= 1'b0;
    end else if (load_clr) begin
      clr_cnt <= CLR_W'(CLEAR_CYCLES);
      Nclear  <= (CLEAR_CYCLES == 0);
    end else if (clr_cnt != '0) begin
      clr_cnt <= clr_cnt - CLR_W'(1);
      Nclear  <= (clr_cnt == CLR_W'(1));
    end else begin
      Nclear  <= 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_cronometro.sv
// Bench for control_cronometro: directed scenarios plus randomized button
// activity, checked every cycle against a window-based behavioural model.
module tb_control_cronometro;

  localparam int DEB  = 4;
  localparam int CLR  = 2;
  localparam int MAXE = 16384;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  logic       NEclk  = 1'b1;
  logic       Nreset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       Enable;
  logic       Nclear;
  logic       lap_hold;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: raw sample history and debounced-level history per button
  int n;
  bit raw_h [2][MAXE];
  bit lvl_h [2][MAXE];
  int last_flip [2];
  int m_state;
  int clear_end;

  control_cronometro #(.DEBOUNCE(DEB), .CLEAR_CYCLES(CLR)) dut (
    .NEclk          (NEclk),
    .Nreset         (Nreset),
    .btn_start_stop (btn_ss),
    .btn_lap_reset  (btn_lr),
    .Enable         (Enable),
    .Nclear         (Nclear),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  always #5 NEclk = ~NEclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit synced(input int b, input int e);
    return (e - 2 >= 1) ? raw_h[b][e-2] : 1'b0;
  endfunction

  function automatic bit lvl_at(input int b, input int e);
    return (e >= 1) ? lvl_h[b][e] : 1'b0;
  endfunction

  // Press pulse visible to the state machine at edge e
  function automatic bit press_seen(input int b, input int e);
    return lvl_at(b, e - 2) & ~lvl_at(b, e - 3);
  endfunction

  task automatic model_reset();
    n            = 0;
    last_flip[0] = 0;
    last_flip[1] = 0;
    m_state      = S_IDLE;
    clear_end    = CLR;
  endtask

  task automatic model_edge(input bit ss, input bit lr);
    bit ps, pl, cur, flip, nclr_before;
    n++;
    raw_h[0][n] = ss;
    raw_h[1][n] = lr;
    for (int b = 0; b < 2; b++) begin
      cur  = lvl_at(b, n - 1);
      flip = (n - last_flip[b] >= DEB);
      for (int j = n - DEB + 1; j <= n; j++)
        if (flip && synced(b, j) == cur) flip = 1'b0;
      lvl_h[b][n] = flip ? ~cur : cur;
      if (flip) last_flip[b] = n;
    end
    ps          = press_seen(0, n);
    pl          = press_seen(1, n);
    nclr_before = (n - 1) >= clear_end;
    if (!nclr_before) begin
      ps = 1'b0;
      pl = 1'b0;
    end
    case (m_state)
      S_IDLE:  if (ps) m_state = S_RUN;
      S_RUN:   if (ps) m_state = S_PAUSE; else if (pl) m_state = S_LAP;
      S_LAP:   if (ps) m_state = S_PAUSE; else if (pl) m_state = S_RUN;
      default: begin
        if (ps) m_state = S_RUN;
        else if (pl) begin
          m_state   = S_IDLE;
          clear_end = n + CLR;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state",    state,    m_state);
    check("enable",   Enable,   (m_state == S_RUN) || (m_state == S_LAP));
    check("lap_hold", lap_hold, m_state == S_LAP);
    check("nclear",   Nclear,   n >= clear_end);
  endtask

  // One clock: drive buttons, let a falling edge pass, compare on the rising edge
  task automatic cycle(input bit ss, input bit lr);
    btn_ss = ss;
    btn_lr = lr;
    @(negedge NEclk);
    if (Nreset) model_edge(ss, lr);
    @(posedge NEclk);
    compare_all();
  endtask

  task automatic btn_press(input bit ss, input bit lr, input int hold);
    for (int i = 0; i < hold; i++) cycle(ss, lr);
    for (int i = 0; i < DEB + 5; i++) cycle(1'b0, 1'b0);
  endtask

  // Assert reset between edges, check immediate values, release mid-cycle
  task automatic do_reset();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    #2 Nreset = 1'b0;
    #1;
    model_reset();
    check("rst_state",  state,    0);
    check("rst_enable", Enable,   0);
    check("rst_lap",    lap_hold, 0);
    check("rst_nclear", Nclear,   0);
    @(negedge NEclk);
    #1 check("rst_hold_nclear", Nclear, 0);
    @(posedge NEclk);
    #2 Nreset = 1'b1;
  endtask

  initial begin : main
    int lat;
    int lows;
    bit sv, lv, bnc;
    int len;

    @(posedge NEclk);
    do_reset();
    cycle(1'b0, 1'b0);
    check("rel_nclear_e1", Nclear, 0);
    cycle(1'b0, 1'b0);
    check("rel_nclear_e2", Nclear, 1);
    check("rel_state", state, 0);
    repeat (3) cycle(1'b0, 1'b0);

    // Short glitch on start/stop is filtered out
    btn_press(1'b1, 1'b0, 2);
    check("bounce_idle", state, 0);

    // Held start/stop: one transition after the debounce latency
    cycle(1'b1, 1'b0);
    lat = 0;
    while (state != 2'd1 && lat < 20) begin
      cycle(1'b1, 1'b0);
      lat++;
    end
    check("ss_latency", lat, DEB + 3);
    check("ss_enable", Enable, 1);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (DEB + 5) cycle(1'b0, 1'b0);
    check("held_once", state, 1);

    // Lap in and out
    btn_press(1'b0, 1'b1, 6);
    check("lap_state", state, 3);
    check("lap_hold_on", lap_hold, 1);
    check("lap_enable", Enable, 1);
    btn_press(1'b0, 1'b1, 6);
    check("unlap_state", state, 1);
    check("unlap_hold", lap_hold, 0);

    // Pause, resume without clear, pause again, then clear with an ignored start
    btn_press(1'b1, 1'b0, 6);
    check("pause_state", state, 2);
    check("pause_enable", Enable, 0);
    btn_press(1'b1, 1'b0, 6);
    check("resume_state", state, 1);
    check("resume_nclear", Nclear, 1);
    btn_press(1'b1, 1'b0, 6);
    check("pause2_state", state, 2);
    lows = 0;
    cycle(1'b0, 1'b1);
    if (!Nclear) lows++;
    repeat (6) begin
      cycle(1'b1, 1'b1);
      if (!Nclear) lows++;
    end
    repeat (DEB + 6) begin
      cycle(1'b0, 1'b0);
      if (!Nclear) lows++;
    end
    check("clear_len", lows, CLR);
    check("clear_ss_ignored", state, 0);

    // Simultaneous presses from LAP: start/stop wins
    btn_press(1'b1, 1'b0, 6);
    btn_press(1'b0, 1'b1, 6);
    check("to_lap", state, 3);
    btn_press(1'b1, 1'b1, 6);
    check("simul_state", state, 2);
    check("simul_lap", lap_hold, 0);
    repeat (5) cycle(1'b0, 1'b0);
    check("simul_stable", state, 2);

    // Reset while running
    btn_press(1'b1, 1'b0, 6);
    check("run_again", state, 1);
    do_reset();
    cycle(1'b0, 1'b0);
    check("rr_nclear_e1", Nclear, 0);
    cycle(1'b0, 1'b0);
    check("rr_nclear_e2", Nclear, 1);
    check("rr_state", state, 0);

    // Randomized button activity with bounce and occasional resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      sv  = 1'($urandom_range(0, 1));
      lv  = 1'($urandom_range(0, 2) == 0);
      bnc = 1'($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        cycle(sv ^ (bnc && $urandom_range(0, 3) == 0),
              lv ^ (bnc && $urandom_range(0, 3) == 0));
      len = $urandom_range(0, 8);
      for (int i = 0; i < len; i++) cycle(1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
